flash_bridge: RTL and testbench

FLASH_BRIDGE -- requirements
Module: flash_bridge

---
 rtl/flash_pkg.sv | 32 +++
 rtl/flash_phy.sv | 77 +++++++
 rtl/flash_bridge.sv | 186 ++++++++++++++++++
 tb/tb_flash_bridge.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// flash_pkg -- shared definitions for the flash bridge.
//   Command opcodes, status-register bit positions and FSM state codes.
//   Optional feature macro: FLASH_BRIDGE_ERASE_EN adds the block-erase states.
package flash_pkg;

  localparam logic [15:0] CMD_PROGRAM       = 16'h0040;
  localparam logic [15:0] CMD_READ_ARRAY    = 16'h00FF;
  localparam logic [15:0] CMD_ERASE_SETUP   = 16'h0020;
  localparam logic [15:0] CMD_ERASE_CONFIRM = 16'h00D0;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;

  // Codes are visible on state_o, so they are fixed explicitly.
  typedef enum logic [3:0] {
    IDLE     = 4'h0,
    RD_LO    = 4'h1,
    RD_HI    = 4'h2,
    WR_CMD   = 4'h3,
    WR_DATA  = 4'h4,
    POLL     = 4'h5,
    RD_ARRAY = 4'h6,
    ACK      = 4'h7
`ifdef FLASH_BRIDGE_ERASE_EN
    ,
    ER_SETUP = 4'h8,
    ER_CONF  = 4'h9
`endif
  } state_e;

endpackage

// File: rtl/flash_phy.sv
// flash_phy -- one flash access: strobes low ACCESS_CYC cycles, then one
// recovery cycle with all strobes high.
//   i_start/i_we/i_addr/i_wdata : access request, accepted on the start edge
//   o_done                      : high during the recovery cycle; a new start
//                                 may be issued in that same cycle
//   o_rdata                     : data captured on the last strobe cycle
//   flash_*                     : flash pins (flash_data driven only while
//                                 flash_we_n is low)
module flash_phy
  import flash_pkg::*;
#(
  parameter int FLASH_AW   = 22,
  parameter int ACCESS_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_we,
  input  logic [FLASH_AW-1:0] i_addr,
  input  logic [15:0]         i_wdata,
  output logic                o_done,
  output logic [15:0]         o_rdata,
  output logic [FLASH_AW-1:0] flash_addr,
  inout  wire  [15:0]         flash_data,
  output logic                flash_ce_n,
  output logic                flash_oe_n,
  output logic                flash_we_n
);

  localparam int CW = (ACCESS_CYC > 2) ? $clog2(ACCESS_CYC) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_act;
  logic          r_rec;
  logic [15:0]   r_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_act      <= 1'b0;
      r_rec      <= 1'b0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      o_rdata    <= '0;
      flash_addr <= '0;
      flash_ce_n <= 1'b1;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
    end else if (i_start) begin
      r_act      <= 1'b1;
      r_rec      <= 1'b0;
      r_cnt      <= '0;
      r_wdata    <= i_wdata;
      flash_addr <= i_addr;
      flash_ce_n <= 1'b0;
      flash_oe_n <= i_we;
      flash_we_n <= !i_we;
    end else if (r_act) begin
      if (r_cnt == CW'(ACCESS_CYC - 1)) begin
        // Last strobe cycle: sample while OE is still low, then release.
        if (!flash_oe_n) o_rdata <= flash_data;
        r_act      <= 1'b0;
        r_rec      <= 1'b1;
        flash_ce_n <= 1'b1;
        flash_oe_n <= 1'b1;
        flash_we_n <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_rec <= 1'b0;
    end
  end

  assign o_done     = r_rec;
  assign flash_data = flash_we_n ? 16'hzzzz : r_wdata;

endmodule

// File: rtl/flash_bridge.sv
// flash_bridge -- 32-bit bus to 16-bit command-set flash bridge.
//   bus_*     : single-request bus; ack is a one-cycle pulse, err valid with ack
//   flash_*   : flash pins (halfword address, tristate data, active-low strobes)
//   state_o   : current FSM state code for debug
// Reads fetch two halfwords (low, high); writes issue program, data, status
// polls and read-array. Define FLASH_BRIDGE_ERASE_EN to turn writes with
// bus_addr_i[31]=1 into block erases.
module flash_bridge
  import flash_pkg::*;
#(
  parameter int FLASH_AW   = 22,
  parameter int ACCESS_CYC = 4,
  parameter int POLL_MAX   = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         bus_addr_i,
  input  logic [31:0]         bus_data_i,
  output logic [31:0]         bus_data_o,
  input  logic                bus_select_i,
  input  logic                bus_we_i,
  output logic                bus_ack_o,
  output logic                bus_err_o,
  output logic [FLASH_AW-1:0] flash_addr,
  inout  wire  [15:0]         flash_data,
  output logic                flash_ce_n,
  output logic                flash_oe_n,
  output logic                flash_we_n,
  output logic [7:0]          state_o
);

  localparam int PCW = $clog2(POLL_MAX + 1);

  state_e              r_state;
  logic [FLASH_AW-1:0] r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_lo;
  logic [PCW-1:0]      r_poll;

  logic                w_start;
  logic                w_we;
  logic [FLASH_AW-1:0] w_paddr;
  logic [15:0]         w_pdata;
  logic                w_done;
  logic [15:0]         w_rdata;
  logic [FLASH_AW-1:0] w_hw;
  logic                w_timeout;
  logic                w_erase;
  logic                w_unused;

  assign w_hw      = bus_addr_i[FLASH_AW:1];
  assign w_timeout = (r_poll == PCW'(POLL_MAX - 1));
  assign state_o   = {4'h0, r_state};
  assign w_unused  = ^{bus_addr_i[31:FLASH_AW+1], bus_addr_i[0], bus_data_i[31:16]};

`ifdef FLASH_BRIDGE_ERASE_EN
  assign w_erase = bus_addr_i[31];
`else
  assign w_erase = 1'b0;
`endif

  // Next access is issued combinationally so it starts on the same edge the
  // FSM advances; this keeps back-to-back accesses gap-free.
  always_comb begin
    w_start = 1'b0;
    w_we    = 1'b0;
    w_paddr = r_addr;
    w_pdata = CMD_READ_ARRAY;
    case (r_state)
      IDLE: if (bus_select_i) begin
        w_start = 1'b1;
        if (!bus_we_i) begin
          w_paddr = {w_hw[FLASH_AW-1:1], 1'b0};
        end else begin
          w_we    = 1'b1;
          w_paddr = w_hw;
          w_pdata = w_erase ? CMD_ERASE_SETUP : CMD_PROGRAM;
        end
      end
      RD_LO: if (w_done) begin
        w_start = 1'b1;
        w_paddr = {r_addr[FLASH_AW-1:1], 1'b1};
      end
      WR_CMD: if (w_done) begin
        w_start = 1'b1;
        w_we    = 1'b1;
        w_pdata = r_wdata;
      end
      WR_DATA: if (w_done) w_start = 1'b1;
`ifdef FLASH_BRIDGE_ERASE_EN
      ER_SETUP: if (w_done) begin
        w_start = 1'b1;
        w_we    = 1'b1;
        w_pdata = CMD_ERASE_CONFIRM;
      end
      ER_CONF: if (w_done) w_start = 1'b1;
`endif
      POLL: if (w_done) begin
        w_start = 1'b1;
        w_we    = w_rdata[SR_READY] || w_timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_lo       <= '0;
      r_poll     <= '0;
      bus_data_o <= '0;
      bus_ack_o  <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      bus_ack_o <= 1'b0;
      case (r_state)
        IDLE: if (bus_select_i) begin
          r_addr  <= w_hw;
          r_wdata <= bus_data_i[15:0];
          r_poll  <= '0;
          if (!bus_we_i)    r_state <= RD_LO;
          else if (w_erase) r_state <= state_e'(4'h8);
          else              r_state <= WR_CMD;
        end
        RD_LO: if (w_done) begin
          r_lo    <= w_rdata;
          r_state <= RD_HI;
        end
        RD_HI: if (w_done) begin
          bus_data_o <= {w_rdata, r_lo};
          bus_ack_o  <= 1'b1;
          r_state    <= ACK;
        end
        WR_CMD:  if (w_done) r_state <= WR_DATA;
        WR_DATA: if (w_done) r_state <= POLL;
`ifdef FLASH_BRIDGE_ERASE_EN
        ER_SETUP: if (w_done) r_state <= ER_CONF;
        ER_CONF:  if (w_done) r_state <= POLL;
`endif
        POLL: if (w_done) begin
          if (w_rdata[SR_READY]) begin
            bus_err_o <= w_rdata[SR_ERASE_ERR] | w_rdata[SR_PROG_ERR];
            r_state   <= RD_ARRAY;
          end else begin
            if (r_poll != PCW'(POLL_MAX)) r_poll <= r_poll + 1'b1;
            if (w_timeout) begin
              bus_err_o <= 1'b1;
              r_state   <= RD_ARRAY;
            end
          end
        end
        RD_ARRAY: if (w_done) begin
          bus_ack_o <= 1'b1;
          r_state   <= ACK;
        end
        ACK: begin
          bus_err_o <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  flash_phy #(
    .FLASH_AW  (FLASH_AW),
    .ACCESS_CYC(ACCESS_CYC)
  ) u_phy (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_we      (w_we),
    .i_addr    (w_paddr),
    .i_wdata   (w_pdata),
    .o_done    (w_done),
    .o_rdata   (w_rdata),
    .flash_addr(flash_addr),
    .flash_data(flash_data),
    .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n)
  );

endmodule

// File: tb/tb_flash_bridge.sv
module tb_flash_bridge;
  localparam int AW = 22;
  localparam int AC = 4;
  localparam int PM = 8;
  localparam int LIMIT = 500;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   bus_addr_i = '0;
  logic [31:0]   bus_data_i = '0;
  logic [31:0]   bus_data_o;
  logic          bus_select_i = 1'b0;
  logic          bus_we_i = 1'b0;
  logic          bus_ack_o;
  logic          bus_err_o;
  logic [AW-1:0] flash_addr;
  wire  [15:0]   flash_data;
  logic          flash_ce_n, flash_oe_n, flash_we_n;
  logic [7:0]    state_o;

  always #5 clk = ~clk;

  flash_bridge #(.FLASH_AW(AW), .ACCESS_CYC(AC), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst),
    .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_data_o(bus_data_o),
    .bus_select_i(bus_select_i), .bus_we_i(bus_we_i),
    .bus_ack_o(bus_ack_o), .bus_err_o(bus_err_o),
    .flash_addr(flash_addr), .flash_data(flash_data),
    .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
    .state_o(state_o)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [15:0] data;} wr_t;
  typedef struct packed {logic [31:0] data; logic err;} rsp_t;
  wr_t  exp_wr[$];
  rsp_t exp_rsp[$];
  wr_t  e_wr;
  rsp_t e_rsp;

  int n_checks = 0;
  int n_errors = 0;

  // Flash model: array mode returns mem, status mode returns status byte.
  logic [15:0] mem [0:255];
  logic        m_status = 1'b0;
  int          busy = 0;
  logic [7:0]  stat_val = 8'h80;
  int          poll_reads = 0;
  logic [31:0] last_rd = '0;
  logic [15:0] m_rd;

  assign m_rd       = m_status ? {8'h00, (busy > 0) ? 8'h00 : stat_val} : mem[flash_addr[7:0]];
  assign flash_data = !flash_oe_n ? m_rd : 16'hzzzz;

  logic p_we_n = 1'b1, p_oe_n = 1'b1, p_ack = 1'b0;
  int   run = 0;

  always @(negedge clk) begin
    if (!rst) begin
      run = 0; p_we_n = 1'b1; p_oe_n = 1'b1; p_ack = 1'b0;
    end else begin
      if (!flash_we_n && p_we_n) begin
        n_checks++;
        if (exp_wr.size() == 0) begin
          n_errors++;
          $display("FAIL flash_write unexpected: got %h@%h, none expected", flash_data, flash_addr);
        end else begin
          e_wr = exp_wr.pop_front();
          if (flash_addr !== e_wr.addr || flash_data !== e_wr.data) begin
            n_errors++;
            $display("FAIL flash_write: got %h@%h, expected %h@%h", flash_data, flash_addr, e_wr.data, e_wr.addr);
          end
        end
        m_status = (flash_data != 16'h00FF);
      end
      if (!flash_oe_n && p_oe_n && m_status) poll_reads++;
      if (flash_oe_n && !p_oe_n && m_status && busy > 0) busy--;
      if (!flash_ce_n) run++;
      else if (run > 0) begin
        n_checks++;
        if (run != AC) begin
          n_errors++;
          $display("FAIL strobe_width: got %0d cycles, expected %0d", run, AC);
        end
        run = 0;
      end
      if (bus_ack_o) begin
        n_checks++;
        if (p_ack) begin
          n_errors++;
          $display("FAIL ack_width: ack high on consecutive cycles");
        end else if (exp_rsp.size() == 0) begin
          n_errors++;
          $display("FAIL ack_unexpected: ack with data %h err %b, none expected", bus_data_o, bus_err_o);
        end else begin
          e_rsp = exp_rsp.pop_front();
          if (bus_data_o !== e_rsp.data || bus_err_o !== e_rsp.err) begin
            n_errors++;
            $display("FAIL ack_response: got data %h err %b, expected data %h err %b",
                     bus_data_o, bus_err_o, e_rsp.data, e_rsp.err);
          end
        end
      end
      p_we_n = flash_we_n; p_oe_n = flash_oe_n; p_ack = bus_ack_o;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w, output int lat);
    @(negedge clk);
    bus_addr_i = a; bus_data_i = d; bus_we_i = w; bus_select_i = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus_select_i = 1'b0;  // dropped early: operation must still complete
    while (!bus_ack_o && lat < LIMIT) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!bus_ack_o) begin
      n_checks++; n_errors++;
      $display("FAIL ack_timeout: no ack within %0d cycles for addr %h", LIMIT, a);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({flash_ce_n, flash_oe_n, flash_we_n} !== 3'b111 || flash_addr !== '0 || bus_data_o !== '0 ||
        bus_ack_o !== 1'b0 || bus_err_o !== 1'b0 || state_o !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_state: strobes %b addr %h data %h ack %b err %b state %h, expected 111/0/0/0/0/00",
               {flash_ce_n, flash_oe_n, flash_we_n}, flash_addr, bus_data_o, bus_ack_o, bus_err_o, state_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_o !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_idle: state %h, expected 00", state_o);
    end
  endtask

  task automatic test_read();
    int lat;
    exp_rsp.push_back('{data: 32'hABCD1234, err: 1'b0});
    issue(32'h0000_0020, 32'h0, 1'b0, lat);
    last_rd = 32'hABCD1234;
    n_checks++;
    if (lat != 2 * (AC + 1) + 1) begin
      n_errors++;
      $display("FAIL read_latency: got %0d cycles, expected %0d", lat, 2 * (AC + 1) + 1);
    end
    // Address bit 1 is ignored: 0x3FE reads halfwords 0x1FE/0x1FF.
    exp_rsp.push_back('{data: {mem[8'hFF], mem[8'hFE]}, err: 1'b0});
    issue(32'h0000_03FE, 32'h0, 1'b0, lat);
    last_rd = {mem[8'hFF], mem[8'hFE]};
  endtask

  task automatic test_program();
    int lat;
    stat_val = 8'h80; busy = 2; poll_reads = 0;
    exp_wr.push_back('{addr: 22'h20, data: 16'h0040});
    exp_wr.push_back('{addr: 22'h20, data: 16'h5A5A});
    exp_wr.push_back('{addr: 22'h20, data: 16'h00FF});
    exp_rsp.push_back('{data: last_rd, err: 1'b0});
    issue(32'h0000_0040, 32'h0000_5A5A, 1'b1, lat);
    n_checks++;
    if (poll_reads != 3 || exp_wr.size() != 0) begin
      n_errors++;
      $display("FAIL program_polls: got %0d polls, %0d writes left, expected 3 and 0", poll_reads, exp_wr.size());
    end
  endtask

  task automatic test_error();
    logic [7:0] st [2];
    int lat;
    st[0] = 8'h90; st[1] = 8'hA0;
    for (int i = 0; i < 2; i++) begin
      stat_val = st[i]; busy = 0; poll_reads = 0;
      exp_wr.push_back('{addr: 22'h80, data: 16'h0040});
      exp_wr.push_back('{addr: 22'h80, data: 16'h7777});
      exp_wr.push_back('{addr: 22'h80, data: 16'h00FF});
      exp_rsp.push_back('{data: last_rd, err: 1'b1});
      issue(32'h0000_0100, 32'hFFFF_7777, 1'b1, lat);
      n_checks++;
      if (poll_reads != 1) begin
        n_errors++;
        $display("FAIL error_polls: status %h got %0d polls, expected 1", st[i], poll_reads);
      end
    end
  endtask

  task automatic test_timeout();
    int lat;
    stat_val = 8'h80; busy = 1000; poll_reads = 0;
    exp_wr.push_back('{addr: 22'h20, data: 16'h0040});
    exp_wr.push_back('{addr: 22'h20, data: 16'h0001});
    exp_wr.push_back('{addr: 22'h20, data: 16'h00FF});
    exp_rsp.push_back('{data: last_rd, err: 1'b1});
    issue(32'h0000_0040, 32'h0000_0001, 1'b1, lat);
    n_checks++;
    if (poll_reads != PM) begin
      n_errors++;
      $display("FAIL timeout_polls: got %0d polls, expected %0d", poll_reads, PM);
    end
    busy = 0;
  endtask

  task automatic test_erase();
    int lat;
    stat_val = 8'h80; busy = 0; poll_reads = 0;
`ifdef FLASH_BRIDGE_ERASE_EN
    exp_wr.push_back('{addr: 22'h8000, data: 16'h0020});
    exp_wr.push_back('{addr: 22'h8000, data: 16'h00D0});
`else
    exp_wr.push_back('{addr: 22'h8000, data: 16'h0040});
    exp_wr.push_back('{addr: 22'h8000, data: 16'h1111});
`endif
    exp_wr.push_back('{addr: 22'h8000, data: 16'h00FF});
    exp_rsp.push_back('{data: last_rd, err: 1'b0});
    issue(32'h8001_0000, 32'h0000_1111, 1'b1, lat);
    n_checks++;
    if (exp_wr.size() != 0 || poll_reads != 1) begin
      n_errors++;
      $display("FAIL erase_sequence: %0d writes left, %0d polls, expected 0 and 1", exp_wr.size(), poll_reads);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    bus_addr_i = 32'h20; bus_we_i = 1'b0; bus_select_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_select_i = 1'b0;
    n = 0;
    while (state_o != 8'h02 && n < LIMIT) begin @(negedge clk); n++; end
    n_checks++;
    if (state_o != 8'h02) begin
      n_errors++;
      $display("FAIL reset_mid_reach: state %h, expected 02", state_o);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({flash_ce_n, flash_oe_n, flash_we_n} !== 3'b111 || bus_ack_o !== 1'b0 || state_o !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_mid: strobes %b ack %b state %h, expected 111/0/00",
               {flash_ce_n, flash_oe_n, flash_we_n}, bus_ack_o, state_o);
    end
    rst = 1'b1;
    repeat (15) @(negedge clk);  // any stray ack is flagged by the monitor
    last_rd = '0;
    n_checks++;
    if (bus_data_o !== 32'h0 || state_o !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_mid_after: data %h state %h, expected 0/00", bus_data_o, state_o);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    exp_rsp.push_back('{data: {mem[8'h11], mem[8'h10]}, err: 1'b0});
    exp_rsp.push_back('{data: {mem[8'h13], mem[8'h12]}, err: 1'b0});
    @(negedge clk);
    bus_addr_i = 32'h20; bus_we_i = 1'b0; bus_select_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_ack_o && n < LIMIT);
    bus_addr_i = 32'h24;
    @(negedge clk);
    n_checks++;
    if (state_o !== 8'h00 || bus_ack_o !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_gap: state %h ack %b after first ack, expected 00/0", state_o, bus_ack_o);
    end
    @(posedge clk);
    @(negedge clk);
    bus_select_i = 1'b0;
    n = 0;
    while (!bus_ack_o && n < LIMIT) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    last_rd = {mem[8'h13], mem[8'h12]};
    n_checks++;
    if (exp_rsp.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_acks: %0d responses outstanding, expected 0", exp_rsp.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'hC3A5;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'hABCD;
    test_reset();
    test_read();
    test_program();
    test_error();
    test_timeout();
    test_erase();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_wr.size() != 0 || exp_rsp.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d writes, %0d responses outstanding, expected 0", exp_wr.size(), exp_rsp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
